// File: rtl/prefix_encoder.sv
// Serialises an x86 instruction prefix/opcode request into a byte stream, one byte per out handshake.
// First byte one cycle after acceptance, then 1 byte/cycle; out_ready low holds the current byte.
module prefix_encoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_rep,
  input  logic       req_lock,
  input  logic [2:0] req_seg,
  input  logic       req_opsize,
  input  logic       req_addrsize,
  input  logic       req_2byte,
  input  logic [7:0] req_opcode,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       out_last,
  output logic       out_is_prefix,
  output logic [3:0] byte_count,
  output logic       req_err,
  output logic       busy
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t     state, state_nx;
  logic       accept, xfer;
  logic [6:0] mask;
  logic [1:0] rep;
  logic [2:0] seg;
  logic [7:0] opcode;
  logic [2:0] item;
  logic [7:0] item_byte;
  logic [7:0] seg_byte;

  assign req_ready     = (state == IDLE) && !flush;
  assign accept        = req_valid && req_ready;
  assign out_valid     = (state == EMIT);
  assign xfer          = out_valid && out_ready;
  assign out_last      = out_valid && (item == 3'd6);
  assign out_is_prefix = out_valid && !out_last;
  assign out_byte      = out_valid ? item_byte : 8'h00;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nx = EMIT;
        EMIT:    if (xfer && out_last) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Mask bits in emission order: F0, rep, seg, 66, 67, 0F, opcode (always set).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask       <= 7'b0;
      rep        <= 2'b0;
      seg        <= 3'b0;
      opcode     <= 8'h00;
      byte_count <= 4'd0;
      req_err    <= 1'b0;
    end else begin
      req_err <= accept && ((req_rep == 2'd3) || (req_seg == 3'd6));
      if (accept) begin
        mask       <= {1'b1, req_2byte, req_addrsize, req_opsize,
                       (req_seg != 3'd7) && (req_seg != 3'd6),
                       (req_rep == 2'd1) || (req_rep == 2'd2),
                       req_lock};
        rep        <= req_rep;
        seg        <= req_seg;
        opcode     <= req_opcode;
        byte_count <= 4'd0;
      end else if (xfer) begin
        mask       <= mask & ~(7'b1 << item);
        byte_count <= byte_count + 4'd1;
      end
    end
  end

  // Lowest remaining mask bit is the item on the bus; opcode is the fallback.
  always_comb begin
    item = 3'd6;
    for (int i = 5; i >= 0; i--) begin
      if (mask[i]) item = 3'(i);
    end
  end

  always_comb begin
    seg_byte = 8'h00;
    case (seg)
      3'd0:    seg_byte = 8'h26;
      3'd1:    seg_byte = 8'h2E;
      3'd2:    seg_byte = 8'h36;
      3'd3:    seg_byte = 8'h3E;
      3'd4:    seg_byte = 8'h64;
      3'd5:    seg_byte = 8'h65;
      default: seg_byte = 8'h00;
    endcase
  end

  always_comb begin
    item_byte = 8'h00;
    case (item)
      3'd0:    item_byte = 8'hF0;
      3'd1:    item_byte = (rep == 2'd1) ? 8'hF2 : 8'hF3;
      3'd2:    item_byte = seg_byte;
      3'd3:    item_byte = 8'h66;
      3'd4:    item_byte = 8'h67;
      3'd5:    item_byte = 8'h0F;
      default: item_byte = opcode;
    endcase
  end

endmodule

// File: tb/tb_prefix_encoder.sv
// Directed self-checking bench for prefix_encoder.
module tb_prefix_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_rep = 2'd0;
  logic       req_lock = 1'b0;
  logic [2:0] req_seg = 3'd7;
  logic       req_opsize = 1'b0;
  logic       req_addrsize = 1'b0;
  logic       req_2byte = 1'b0;
  logic [7:0] req_opcode = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_byte;
  logic       out_last;
  logic       out_is_prefix;
  logic [3:0] byte_count;
  logic       req_err;
  logic       busy;

  int passed = 0;
  int total  = 0;

  prefix_encoder dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rep(req_rep), .req_lock(req_lock), .req_seg(req_seg),
    .req_opsize(req_opsize), .req_addrsize(req_addrsize), .req_2byte(req_2byte),
    .req_opcode(req_opcode),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_last(out_last), .out_is_prefix(out_is_prefix),
    .byte_count(byte_count), .req_err(req_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] rep, input logic lock, input logic [2:0] seg,
                      input logic ops, input logic adr, input logic two, input logic [7:0] opc);
    req_rep = rep; req_lock = lock; req_seg = seg;
    req_opsize = ops; req_addrsize = adr; req_2byte = two; req_opcode = opc;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (out_byte !== 8'h00) $display("FAIL rst_out_byte: got %h want 00", out_byte); else passed++;
    total++; if (out_last !== 1'b0 || out_is_prefix !== 1'b0) $display("FAIL rst_last_prefix: got %b%b want 00", out_last, out_is_prefix); else passed++;
    total++; if (byte_count !== 4'd0) $display("FAIL rst_byte_count: got %0d want 0", byte_count); else passed++;
    total++; if (busy !== 1'b0 || req_err !== 1'b0) $display("FAIL rst_busy_err: got %b%b want 00", busy, req_err); else passed++;
    #14 rst_n = 1'b1;
    tick();
    total++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b want 1", req_ready); else passed++;
  endtask

  task automatic test_full();
    logic [7:0] exp [7];
    exp = '{8'hF0, 8'hF3, 8'h64, 8'h66, 8'h67, 8'h0F, 8'hAF};
    out_ready = 1'b1;
    send(2'd2, 1'b1, 3'd4, 1'b1, 1'b1, 1'b1, 8'hAF);
    total++; if (byte_count !== 4'd0) $display("FAIL full_count_start: got %0d want 0", byte_count); else passed++;
    for (int i = 0; i < 7; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_byte !== exp[i] || out_last !== (i == 6) || out_is_prefix !== (i != 6))
        $display("FAIL full_byte%0d: got v=%b b=%h l=%b p=%b want v=1 b=%h l=%b p=%b",
                 i, out_valid, out_byte, out_last, out_is_prefix, exp[i], i == 6, i != 6);
      else passed++;
      tick();
    end
    total++; if (byte_count !== 4'd7) $display("FAIL full_count: got %0d want 7", byte_count); else passed++;
    total++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL full_idle: got busy=%b v=%b want 0 0", busy, out_valid); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL full_ready: got %b want 1", req_ready); else passed++;
  endtask

  task automatic test_minimal();
    out_ready = 1'b1;
    send(2'd0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 8'h90);
    total++; if (out_valid !== 1'b1 || out_byte !== 8'h90) $display("FAIL min_byte: got v=%b b=%h want v=1 b=90", out_valid, out_byte); else passed++;
    total++; if (out_last !== 1'b1 || out_is_prefix !== 1'b0) $display("FAIL min_flags: got l=%b p=%b want l=1 p=0", out_last, out_is_prefix); else passed++;
    total++; if (req_ready !== 1'b0 || req_err !== 1'b0) $display("FAIL min_ready_err: got r=%b e=%b want 0 0", req_ready, req_err); else passed++;
    tick();
    total++; if (req_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL min_after: got r=%b v=%b want r=1 v=0", req_ready, out_valid); else passed++;
    total++; if (byte_count !== 4'd1) $display("FAIL min_count: got %0d want 1", byte_count); else passed++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(2'd0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 8'h8B);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_byte !== 8'h36 || out_last !== 1'b0)
        $display("FAIL bp_hold%0d: got v=%b b=%h l=%b want v=1 b=36 l=0", i, out_valid, out_byte, out_last);
      else passed++;
      if (i < 2) tick();
    end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b1 || out_byte !== 8'h8B || out_last !== 1'b1) $display("FAIL bp_op: got v=%b b=%h l=%b want v=1 b=8b l=1", out_valid, out_byte, out_last); else passed++;
    tick();
    total++; if (byte_count !== 4'd2 || busy !== 1'b0) $display("FAIL bp_count: got cnt=%0d busy=%b want 2 0", byte_count, busy); else passed++;
  endtask

  task automatic test_invalid();
    out_ready = 1'b1;
    send(2'd3, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0, 8'hA4);
    total++; if (req_err !== 1'b1) $display("FAIL inv_err_hi: got %b want 1", req_err); else passed++;
    total++; if (out_byte !== 8'hA4 || out_last !== 1'b1) $display("FAIL inv_byte: got b=%h l=%b want A4 1", out_byte, out_last); else passed++;
    tick();
    total++; if (req_err !== 1'b0) $display("FAIL inv_err_lo: got %b want 0", req_err); else passed++;
    total++; if (out_valid !== 1'b0 || byte_count !== 4'd1) $display("FAIL inv_done: got v=%b cnt=%0d want 0 1", out_valid, byte_count); else passed++;
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    send(2'd1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1, 8'hB6);
    total++; if (out_byte !== 8'hF2) $display("FAIL fl_b0: got %h want F2", out_byte); else passed++;
    tick();
    total++; if (out_byte !== 8'h2E) $display("FAIL fl_b1: got %h want 2E", out_byte); else passed++;
    flush = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL fl_drop: got v=%b busy=%b want 0 0", out_valid, busy); else passed++;
    total++; if (byte_count !== 4'd2) $display("FAIL fl_count: got %0d want 2", byte_count); else passed++;
    total++; if (req_ready !== 1'b0) $display("FAIL fl_ready_masked: got %b want 0", req_ready); else passed++;
    // Request presented with flush high must be ignored.
    send(2'd0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 8'h55);
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL fl_priority: got v=%b busy=%b want 0 0", out_valid, busy); else passed++;
    flush = 1'b0;
    send(2'd0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 8'h90);
    total++; if (out_valid !== 1'b1 || out_byte !== 8'h90) $display("FAIL fl_new_req: got v=%b b=%h want 1 90", out_valid, out_byte); else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(2'd0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b1, 8'h31);
    total++; if (out_byte !== 8'h0F) $display("FAIL rm_pre: got %h want 0F", out_byte); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_byte !== 8'h00 || busy !== 1'b0) $display("FAIL rm_async: got v=%b b=%h busy=%b want 0 00 0", out_valid, out_byte, busy); else passed++;
    total++; if (byte_count !== 4'd0) $display("FAIL rm_count: got %0d want 0", byte_count); else passed++;
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL rm_quiet%0d: got %b want 0", i, out_valid); else passed++;
    end
    total++; if (req_ready !== 1'b1) $display("FAIL rm_ready: got %b want 1", req_ready); else passed++;
  endtask

  initial begin
    test_reset();
    test_full();
    test_minimal();
    test_backpressure();
    test_invalid();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/prefix_encoder.md
PREFIX_ENCODER -- requirements
Module: prefix_encoder

Interface
REQ-001 Parameter: none; all widths are fixed.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 flush  in  1  synchronous abort of any request in progress.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  request can be accepted this cycle.
REQ-007 req_rep  in  2  0 = none, 1 = F2 (repne), 2 = F3 (rep/repe), 3 = invalid.
REQ-008 req_lock  in  1  emit F0.
REQ-009 req_seg  in  3  0 = 26, 1 = 2E, 2 = 36, 3 = 3E, 4 = 64, 5 = 65, 7 = none, 6 = invalid.
REQ-010 req_opsize  in  1  emit 66.
REQ-011 req_addrsize  in  1  emit 67.
REQ-012 req_2byte  in  1  emit 0F.
REQ-013 req_opcode  in  8  final opcode byte.
REQ-014 out_valid  out  1  out_byte is valid.
REQ-015 out_ready  in  1  consumer accepts out_byte.
REQ-016 out_byte  out  8  emitted byte.
REQ-017 out_last  out  1  out_byte is the opcode (last byte of the sequence).
REQ-018 out_is_prefix  out  1  out_byte is a prefix byte (F0/F2/F3/segment/66/67/0F).
REQ-019 byte_count  out  4  bytes accepted by the consumer for the current or most recent request.
REQ-020 req_err  out  1  one-cycle pulse when the accepted request had an invalid field.
REQ-021 busy  out  1  FSM is not IDLE.

Function
REQ-022 FSM states: IDLE and EMIT.
REQ-023 req_ready = (state == IDLE) and not flush.
REQ-024 Request acceptance: req_valid and req_ready.
REQ-025 On acceptance, all req_* fields are captured into registers.
REQ-026 On acceptance, an emit mask is built, byte_count clears to 0, and the FSM moves to EMIT.
REQ-027 Emission order (fixed): F0, F2/F3, segment, 66, 67, 0F, opcode; only items enabled in the mask are emitted.
REQ-028 The opcode item is always enabled, so a sequence is 1 to 7 bytes.
REQ-029 out_valid is high in EMIT only.
REQ-030 The first byte is presented the cycle after acceptance; no combinational path exists from req_* to out_*.
REQ-031 out_byte, out_last and out_is_prefix hold stable while out_valid is high and out_ready is low.
REQ-032 On out_valid and out_ready, byte_count increments and the FSM advances to the next enabled item in the following cycle, so throughput is 1 byte per cycle.
REQ-033 On out_valid and out_ready with out_last high, the FSM returns to IDLE.
REQ-034 A new request is accepted no earlier than the cycle after the last byte is transferred (no same-cycle overlap).
REQ-035 Invalid req_rep (3) suppresses the rep byte.
REQ-036 Invalid req_seg (6) suppresses the segment byte.
REQ-037 Either invalid field causes req_err to pulse high for exactly one cycle, the cycle after acceptance; all other items are still emitted.
REQ-038 flush high in any state returns the FSM to IDLE next cycle and drops out_valid next cycle.
REQ-039 A transfer in the same cycle as flush still counts in byte_count.
REQ-040 flush has priority over acceptance: with flush and req_valid in IDLE, the request is not accepted.
REQ-041 byte_count holds its value in IDLE until the next acceptance; it never exceeds 7.
REQ-042 out_is_prefix = out_valid and not out_last.

Reset
REQ-043 While rst_n is low, state = IDLE.
REQ-044 While rst_n is low, out_valid = 0, out_byte = 00, out_last = 0, out_is_prefix = 0.
REQ-045 While rst_n is low, byte_count = 0, req_err = 0, busy = 0, and all captured fields are cleared.
REQ-046 Reset asserted mid-sequence aborts the sequence; no further bytes are emitted after release.
REQ-047 req_ready = 1 on the first cycle after release, provided flush is low.

Verification
REQ-048 Full request with lock=1, rep=2, seg=4, opsize=1, addrsize=1, 2byte=1, opcode=AF, out_ready held 1 -> bytes F0,F3,64,66,67,0F,AF on 7 consecutive cycles; out_last only on AF; byte_count=7; busy falls after AF.
REQ-049 Minimal request with all fields none and opcode=90 -> single byte 90 with out_last=1 and out_is_prefix=0, one cycle after acceptance; req_ready high again the next cycle.
REQ-050 Backpressure: request with seg=2 and opcode=8B; out_ready low for 3 cycles on byte 36 -> out_byte stays 36 and out_valid stays 1; then 36 and 8B transfer; byte_count=2.
REQ-051 Invalid fields: rep=3, seg=6, opcode=A4 -> single byte A4; req_err high exactly one cycle.
REQ-052 Flush after 2 of 5 bytes (request F2, 2E, 66, 0F, B6) -> out_valid low the next cycle; byte_count=2; new request accepted the following cycle.
REQ-053 rst_n asserted while presenting 0F -> all outputs go to reset values immediately; after release, out_valid stays 0 until a new request is accepted.
